// File: rtl/tl_ul_master_pipe.sv
// TileLink-UL style master: CPU strobe commands -> request FIFO -> registered
// A-channel beat, up to MAX_OUTS beats in flight, in-order D responses.
// Optional D-opcode checking is enabled by defining RESP_CHECK_EN; without it
// resp_err is tied low and d_opcode is ignored.
module tl_ul_master_pipe #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUTS   = 2,
    localparam int MASK_W    = DATA_W / 8,
    localparam int CNT_W     = $clog2(MAX_OUTS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic [MASK_W-1:0] cpu_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rdata_v,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              a_ready,
    output logic              a_valid,
    output logic [3:0]        a_opcode,
    output logic [MASK_W-1:0] a_mask,
    output logic [ADDR_W-1:0] a_address,
    output logic [DATA_W-1:0] a_data,
    output logic              d_ready,
    input  logic              d_valid,
    input  logic [3:0]        d_opcode,
    input  logic [DATA_W-1:0] d_data,
    output logic [CNT_W-1:0]  outs_cnt,
    output logic              idle,
    output logic              resp_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PW1   = PTR_W + 1;
    localparam int QP_W  = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam int CW1   = CNT_W + 1;
    localparam logic [QP_W-1:0] TQ_LAST = QP_W'(MAX_OUTS - 1);

    localparam logic [3:0] OP_PUT_FULL = 4'd0;
    localparam logic [3:0] OP_PUT_PART = 4'd1;
    localparam logic [3:0] OP_GET      = 4'd4;

    // Request FIFO storage and pointers (extra MSB distinguishes full/empty)
    logic [3:0]        fifo_op_r   [FIFO_DEPTH];
    logic [MASK_W-1:0] fifo_mask_r [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_r;
    logic [PTR_W:0]    rd_ptr_r;

    // A-stage registered beat
    logic              a_valid_r;
    logic [3:0]        a_opcode_r;
    logic [MASK_W-1:0] a_mask_r;
    logic [ADDR_W-1:0] a_address_r;
    logic [DATA_W-1:0] a_data_r;

    // In-flight tracking: count plus a circular queue of "is read" flags
    logic [CNT_W-1:0]    outs_cnt_r;
    logic [MAX_OUTS-1:0] tq_r;
    logic [QP_W-1:0]     tq_wr_r;
    logic [QP_W-1:0]     tq_rd_r;
    logic                resp_err_r;

    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic              push_s;
    logic              load_s;
    logic              credit_ok_s;
    logic              a_fire_s;
    logic              d_fire_s;
    logic              d_ready_s;
    logic              head_is_read_s;
    logic [3:0]        in_op_s;
    logic [DATA_W-1:0] in_data_s;
    logic              op_bad_s;
    logic              err_set_s;

    // Circular increment for the type queue (depth need not be a power of 2)
    function automatic logic [QP_W-1:0] tq_inc(input logic [QP_W-1:0] p);
        return (p == TQ_LAST) ? '0 : p + QP_W'(1);
    endfunction

    assign fifo_empty_s   = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s    = (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]) &&
                            (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]);
    assign push_s         = (cpu_wr | cpu_rd) & ~fifo_full_s;
    // outs_cnt + a_valid < MAX_OUTS: a held beat already consumes a credit
    assign credit_ok_s    = (CW1'(outs_cnt_r) + CW1'(a_valid_r)) < CW1'(MAX_OUTS);
    assign load_s         = ~fifo_empty_s & (~a_valid_r | a_ready) & credit_ok_s;
    assign a_fire_s       = a_valid_r & a_ready;
    assign d_ready_s      = (outs_cnt_r != '0);
    assign d_fire_s       = d_valid & d_ready_s;
    assign head_is_read_s = tq_r[tq_rd_r];

    // Decode a CPU command into its TileLink opcode and payload; write wins
    always_comb begin
        in_op_s   = OP_GET;
        in_data_s = '0;
        if (cpu_wr) begin
            in_op_s   = (&cpu_byte) ? OP_PUT_FULL : OP_PUT_PART;
            in_data_s = cpu_wdata;
        end else begin
            in_op_s   = OP_GET;
            in_data_s = '0;
        end
    end

`ifdef RESP_CHECK_EN
    // Flag D beats whose opcode disagrees with the outstanding request type
    always_comb begin
        op_bad_s  = 1'b0;
        err_set_s = 1'b0;
        if (d_fire_s) begin
            op_bad_s = (d_opcode != (head_is_read_s ? 4'd1 : 4'd0));
        end else begin
            op_bad_s = 1'b0;
        end
        err_set_s = op_bad_s | (d_valid & ~d_ready_s);
    end
`else
    logic unused_dopcode_s;
    assign unused_dopcode_s = ^d_opcode;
    assign op_bad_s         = 1'b0;
    assign err_set_s        = 1'b0;
`endif

    // FIFO write/read pointer update
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW1'(1);
            end
            if (load_s) begin
                rd_ptr_r <= rd_ptr_r + PW1'(1);
            end
        end
    end

    // FIFO entry storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_op_r[wr_ptr_r[PTR_W-1:0]]   <= in_op_s;
            fifo_mask_r[wr_ptr_r[PTR_W-1:0]] <= cpu_byte;
            fifo_addr_r[wr_ptr_r[PTR_W-1:0]] <= cpu_addr;
            fifo_data_r[wr_ptr_r[PTR_W-1:0]] <= in_data_s;
        end
    end

    // A-stage: load from FIFO head, clear after fire, otherwise hold stable
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_r   <= 1'b0;
            a_opcode_r  <= 4'd0;
            a_mask_r    <= '0;
            a_address_r <= '0;
            a_data_r    <= '0;
        end else if (load_s) begin
            a_valid_r   <= 1'b1;
            a_opcode_r  <= fifo_op_r[rd_ptr_r[PTR_W-1:0]];
            a_mask_r    <= fifo_mask_r[rd_ptr_r[PTR_W-1:0]];
            a_address_r <= fifo_addr_r[rd_ptr_r[PTR_W-1:0]];
            a_data_r    <= fifo_data_r[rd_ptr_r[PTR_W-1:0]];
        end else if (a_fire_s) begin
            a_valid_r   <= 1'b0;
            a_opcode_r  <= 4'd0;
            a_mask_r    <= '0;
            a_address_r <= '0;
            a_data_r    <= '0;
        end
    end

    // Outstanding count: +1 on A fire, -1 on D fire, unchanged on both
    always_ff @(posedge clk) begin
        if (rst) begin
            outs_cnt_r <= '0;
        end else begin
            case ({a_fire_s, d_fire_s})
                2'b10:   outs_cnt_r <= outs_cnt_r + CNT_W'(1);
                2'b01:   outs_cnt_r <= outs_cnt_r - CNT_W'(1);
                default: outs_cnt_r <= outs_cnt_r;
            endcase
        end
    end

    // Type queue: push request kind on A fire, pop on D fire
    always_ff @(posedge clk) begin
        if (rst) begin
            tq_r    <= '0;
            tq_wr_r <= '0;
            tq_rd_r <= '0;
        end else begin
            if (a_fire_s) begin
                tq_r[tq_wr_r] <= (a_opcode_r == OP_GET);
                tq_wr_r       <= tq_inc(tq_wr_r);
            end
            if (d_fire_s) begin
                tq_rd_r <= tq_inc(tq_rd_r);
            end
        end
    end

    // Sticky response error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err_r <= 1'b0;
        end else if (err_set_s) begin
            resp_err_r <= 1'b1;
        end
    end

    assign cpu_ready   = ~fifo_full_s;
    assign cpu_rdata_v = d_fire_s & head_is_read_s & ~op_bad_s;
    assign cpu_rdata   = d_data;
    assign a_valid     = a_valid_r;
    assign a_opcode    = a_opcode_r;
    assign a_mask      = a_mask_r;
    assign a_address   = a_address_r;
    assign a_data      = a_data_r;
    assign d_ready     = d_ready_s;
    assign outs_cnt    = outs_cnt_r;
    assign idle        = fifo_empty_s & ~a_valid_r & (outs_cnt_r == '0);
    assign resp_err    = resp_err_r;

endmodule

// File: tb/tb_tl_ul_master_pipe.sv
// Self-checking bench for tl_ul_master_pipe: directed scenarios followed by a
// randomized phase, all compared against a queue-based transaction model.
module tb_tl_ul_master_pipe;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 32;
    localparam int MASK_W     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_OUTS   = 2;
    localparam int CNT_W      = 2;

    logic              clk;
    logic              rst;
    logic              cpu_wr;
    logic              cpu_rd;
    logic [MASK_W-1:0] cpu_byte;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_rdata_v;
    logic [DATA_W-1:0] cpu_rdata;
    logic              a_ready;
    logic              a_valid;
    logic [3:0]        a_opcode;
    logic [MASK_W-1:0] a_mask;
    logic [ADDR_W-1:0] a_address;
    logic [DATA_W-1:0] a_data;
    logic              d_ready;
    logic              d_valid;
    logic [3:0]        d_opcode;
    logic [DATA_W-1:0] d_data;
    logic [CNT_W-1:0]  outs_cnt;
    logic              idle;
    logic              resp_err;

    tl_ul_master_pipe #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTS(MAX_OUTS)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_byte(cpu_byte),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .cpu_rdata_v(cpu_rdata_v), .cpu_rdata(cpu_rdata),
        .a_ready(a_ready), .a_valid(a_valid), .a_opcode(a_opcode),
        .a_mask(a_mask), .a_address(a_address), .a_data(a_data),
        .d_ready(d_ready), .d_valid(d_valid), .d_opcode(d_opcode), .d_data(d_data),
        .outs_cnt(outs_cnt), .idle(idle), .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]        op;
        logic [MASK_W-1:0] mask;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } beat_t;

    // Reference model: accepted-but-not-fired beats, and kinds of fired beats
    beat_t cmd_q[$];
    bit    tq[$];
    bit    hold_v;
    beat_t hold_b;
    bit    err_m;
    int    n_vec;
    int    n_err;
    int    n_afire;
    int    base;
    int    qsz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check the DUT against the model, update the model, advance.
    task automatic step();
        beat_t obs_b;
        beat_t exp_b;
        bit    d_fire_m;
        bit    exp_v;
        bit    bad;
        bit    err_next;
        #4;
        if (rst) begin
            @(posedge clk);
            #1;
            cmd_q.delete();
            tq.delete();
            hold_v = 1'b0;
            err_m  = 1'b0;
            return;
        end
        obs_b = {a_opcode, a_mask, a_address, a_data};
        chk("outs_cnt", outs_cnt, tq.size());
        chk("d_ready", d_ready, tq.size() != 0);
        chk("idle", idle, (cmd_q.size() == 0) && (tq.size() == 0));
        chk("cpu_ready", cpu_ready, (cmd_q.size() - int'(a_valid)) < FIFO_DEPTH);
        chk("resp_err", resp_err, err_m);
        if (hold_v) begin
            chk("hold_valid", a_valid, 1);
            chk("hold_beat", obs_b, hold_b);
        end
        d_fire_m = d_valid && (tq.size() != 0);
        bad      = 1'b0;
`ifdef RESP_CHECK_EN
        if (d_fire_m) bad = (d_opcode != (tq[0] ? 4'd1 : 4'd0));
        err_next = err_m | bad | (d_valid && (tq.size() == 0));
`else
        err_next = 1'b0;
`endif
        if (d_fire_m) begin
            exp_v = tq[0] & ~bad;
            chk("rdata_v", cpu_rdata_v, exp_v);
            if (exp_v) chk("rdata", cpu_rdata, d_data);
            void'(tq.pop_front());
        end else begin
            chk("rdata_v_quiet", cpu_rdata_v, 0);
        end
        if (a_valid && a_ready) begin
            n_afire++;
            if (cmd_q.size() == 0) begin
                chk("a_spurious", a_valid, 0);
            end else begin
                exp_b = cmd_q.pop_front();
                chk("a_beat", obs_b, exp_b);
                tq.push_back(exp_b.op == 4'd4);
                chk("outs_bound", tq.size() <= MAX_OUTS, 1);
            end
        end
        if ((cpu_wr || cpu_rd) && cpu_ready) begin
            exp_b.op   = cpu_wr ? ((cpu_byte == 4'hF) ? 4'd0 : 4'd1) : 4'd4;
            exp_b.mask = cpu_byte;
            exp_b.addr = cpu_addr;
            exp_b.data = cpu_wr ? cpu_wdata : 32'd0;
            cmd_q.push_back(exp_b);
        end
        hold_v = a_valid && !a_ready;
        hold_b = obs_b;
        err_m  = err_next;
        @(posedge clk);
        #1;
    endtask

    // Act as a well-behaved slave until every accepted command is answered.
    task automatic drain();
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (cmd_q.size() == 0 && tq.size() == 0) break;
            a_ready  = 1'b1;
            d_valid  = (tq.size() != 0);
            d_opcode = 4'd0;
            if (tq.size() != 0) d_opcode = tq[0] ? 4'd1 : 4'd0;
            d_data   = $urandom;
            step();
        end
        d_valid = 1'b0;
        a_ready = 1'b0;
        chk("drain_idle", idle, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0; n_err = 0; n_afire = 0; hold_v = 1'b0; err_m = 1'b0;
        rst = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_byte = 4'h0; cpu_addr = 4'h0;
        cpu_wdata = 32'h0; a_ready = 1'b0; d_valid = 1'b0; d_opcode = 4'h0; d_data = 32'h0;
        @(posedge clk);
        #1;

        // Reset then idle
        step();
        step();
        rst = 1'b0;
        chk("rst_a_valid", a_valid, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_cpu_ready", cpu_ready, 1);
        chk("rst_idle", idle, 1);
        chk("rst_outs", outs_cnt, 0);
        chk("rst_resp_err", resp_err, 0);

        // Full write, latency and AccessAck
        cpu_wr = 1'b1; cpu_byte = 4'hF; cpu_addr = 4'd3; cpu_wdata = 32'hDEADBEEF; a_ready = 1'b1;
        step();
        cpu_wr = 1'b0;
        chk("lat_e0_valid", a_valid, 0);
        step();
        chk("lat_e1_valid", a_valid, 1);
        chk("full_wr_beat", {a_opcode, a_mask, a_address, a_data}, {4'd0, 4'hF, 4'd3, 32'hDEADBEEF});
        step();
        chk("full_wr_outs1", outs_cnt, 1);
        d_valid = 1'b1; d_opcode = 4'd0; d_data = 32'h0;
        #1;
        chk("full_wr_rdata_v", cpu_rdata_v, 0);
        step();
        d_valid = 1'b0;
        chk("full_wr_outs0", outs_cnt, 0);

        // Partial write then read, AccessAckData delivers read data
        cpu_wr = 1'b1; cpu_byte = 4'h3; cpu_addr = 4'd5; cpu_wdata = 32'h0000_55AA;
        step();
        cpu_wr = 1'b0; cpu_rd = 1'b1; cpu_byte = 4'hF; cpu_addr = 4'd5;
        step();
        cpu_rd = 1'b0;
        for (int i = 0; i < 10 && outs_cnt != 2'd2; i++) step();
        chk("pw_rd_outs2", outs_cnt, 2);
        d_valid = 1'b1; d_opcode = 4'd0;
        step();
        d_opcode = 4'd1; d_data = 32'h1234;
        #1;
        chk("rd_rdata_v", cpu_rdata_v, 1);
        chk("rd_rdata", cpu_rdata, 32'h1234);
        step();
        d_valid = 1'b0;
        #1;
        chk("rd_rdata_v_drop", cpu_rdata_v, 0);
        drain();

        // Credit limit and backpressure hold
        base = n_afire;
        a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_rd = 1'b1; cpu_byte = 4'hF; cpu_addr = 4'(i + 8);
            step();
        end
        cpu_rd = 1'b0;
        repeat (6) step();
        chk("credit_fires", n_afire - base, 2);
        chk("credit_outs", outs_cnt, 2);
        chk("credit_no_beat", a_valid, 0);
        a_ready = 1'b0; d_valid = 1'b1; d_opcode = 4'd1; d_data = $urandom;
        step();
        d_valid = 1'b0;
        step();
        chk("third_beat", a_valid, 1);
        repeat (5) step();
        chk("hold_after5", a_valid, 1);
        drain();

        // FIFO full: 4 stored plus 1 in the A stage, the sixth is dropped
        a_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cpu_wr = 1'b1; cpu_byte = 4'hF; cpu_addr = 4'(i); cpu_wdata = $urandom;
            step();
        end
        cpu_wr = 1'b0;
        qsz = cmd_q.size();
        chk("full_accepted", qsz, 5);
        chk("full_cpu_ready", cpu_ready, 0);
        drain();

        // Read answered with AccessAck (opcode 0)
        cpu_rd = 1'b1; cpu_byte = 4'hF; cpu_addr = 4'd7; a_ready = 1'b1;
        step();
        cpu_rd = 1'b0;
        for (int i = 0; i < 10 && outs_cnt != 2'd1; i++) step();
        chk("bad_op_outs1", outs_cnt, 1);
        d_valid = 1'b1; d_opcode = 4'd0; d_data = 32'hCAFE;
        #1;
`ifdef RESP_CHECK_EN
        chk("bad_op_rdata_v", cpu_rdata_v, 0);
`else
        chk("bad_op_rdata_v", cpu_rdata_v, 1);
`endif
        step();
        d_valid = 1'b0;
`ifdef RESP_CHECK_EN
        chk("bad_op_err", resp_err, 1);
        repeat (3) step();
        chk("bad_op_sticky", resp_err, 1);
`else
        chk("bad_op_err", resp_err, 0);
        repeat (3) step();
        chk("bad_op_sticky", resp_err, 0);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("err_cleared", resp_err, 0);
        a_ready = 1'b0;

        // Randomized traffic with occasional mid-transaction reset
        for (int i = 0; i < 500; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            cpu_wr    = ($urandom_range(0, 2) == 0);
            cpu_rd    = ($urandom_range(0, 2) == 0);
            cpu_byte  = 4'($urandom);
            cpu_addr  = 4'($urandom);
            cpu_wdata = $urandom;
            a_ready   = ($urandom_range(0, 3) != 0);
            d_valid   = ($urandom_range(0, 2) == 0);
            d_opcode  = 4'd0;
            if (tq.size() != 0) d_opcode = tq[0] ? 4'd1 : 4'd0;
            d_data    = $urandom;
            step();
        end
        rst = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
